// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus 32-bit datapath.
// Optional single-step mode: define SINGLE_STEP_EN to add the step input.
module control_sequencer #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [28:0] ctrl,
  output logic [4:0]  operation,
  output logic        run
);

  localparam logic [1:0] MW = 2'(MEM_WAIT);

  localparam logic [28:0] PCOUT  = 29'd1 << 28;
  localparam logic [28:0] PCIN   = 29'd1 << 27;
  localparam logic [28:0] INCPC  = 29'd1 << 26;
  localparam logic [28:0] MARIN  = 29'd1 << 25;
  localparam logic [28:0] MDRIN  = 29'd1 << 24;
  localparam logic [28:0] MDROUT = 29'd1 << 23;
  localparam logic [28:0] READ   = 29'd1 << 22;
  localparam logic [28:0] RAMWE  = 29'd1 << 21;
  localparam logic [28:0] IRIN   = 29'd1 << 20;
  localparam logic [28:0] YIN    = 29'd1 << 19;
  localparam logic [28:0] ZLIN   = 29'd1 << 18;
  localparam logic [28:0] ZHIN   = 29'd1 << 17;
  localparam logic [28:0] ZLOUT  = 29'd1 << 16;
  localparam logic [28:0] ZHOUT  = 29'd1 << 15;
  localparam logic [28:0] HIIN   = 29'd1 << 14;
  localparam logic [28:0] HIOUT  = 29'd1 << 13;
  localparam logic [28:0] LOIN   = 29'd1 << 12;
  localparam logic [28:0] LOOUT  = 29'd1 << 11;
  localparam logic [28:0] GRA    = 29'd1 << 10;
  localparam logic [28:0] GRB    = 29'd1 << 9;
  localparam logic [28:0] GRC    = 29'd1 << 8;
  localparam logic [28:0] RIN    = 29'd1 << 7;
  localparam logic [28:0] ROUT   = 29'd1 << 6;
  localparam logic [28:0] BAOUT  = 29'd1 << 5;
  localparam logic [28:0] COUT   = 29'd1 << 4;
  localparam logic [28:0] CONIN  = 29'd1 << 3;
  localparam logic [28:0] INPOUT = 29'd1 << 2;
  localparam logic [28:0] OUTPIN = 29'd1 << 1;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4,
    S_T5, S_T6, S_T7, S_HALT, S_WAIT
  } state_t;

  state_t     state;
  state_t     fin;
  state_t     wait_next;
  logic [1:0] cnt;
  logic [4:0] opc;
  logic [4:0] imm_op;
  logic [28:0] stall;
  logic       hold;
  logic       last;
  logic       unused;

  logic c_alu, c_imm, c_neg, c_md, c_ld, c_ldi, c_st;
  logic c_br, c_jr, c_in, c_out, c_mfhi, c_mflo, c_halt;
  logic c_mem, c_one;

  assign opc    = ir[31:27];
  assign unused = ^ir[26:0];

  assign c_alu  = opc inside {[5'd3:5'd11]};
  assign c_imm  = opc inside {[5'd12:5'd14]};
  assign c_md   = opc inside {5'd15, 5'd16};
  assign c_neg  = opc inside {5'd17, 5'd18};
  assign c_ld   = opc == 5'd0;
  assign c_ldi  = opc == 5'd1;
  assign c_st   = opc == 5'd2;
  assign c_br   = opc == 5'd19;
  assign c_jr   = opc == 5'd20;
  assign c_in   = opc == 5'd22;
  assign c_out  = opc == 5'd23;
  assign c_mfhi = opc == 5'd24;
  assign c_mflo = opc == 5'd25;
  assign c_halt = opc == 5'd27;
  assign c_mem  = c_ld | c_ldi | c_st;
  assign c_one  = ~(c_alu | c_imm | c_md | c_neg |
                    c_mem | c_br | c_halt);

  assign imm_op = (opc == 5'd12) ? 5'd3 :
                  (opc == 5'd13) ? 5'd5 : 5'd6;

  // RAM reads hold Read/MDRin until the wait count is used up
  assign hold  = (state == S_T1 || (state == S_T6 && c_ld)) &&
                 (cnt != MW);
  assign stall = {28'd0, cnt != 2'd0};

  always_comb begin
    last = 1'b0;
    unique case (state)
      S_T3:    last = c_one;
      S_T4:    last = c_neg;
      S_T5:    last = c_alu | c_imm | c_ldi;
      S_T6:    last = c_md | c_br;
      S_T7:    last = 1'b1;
      default: last = 1'b0;
    endcase
  end

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic rise;

  assign rise = step & ~step_q;
  assign fin  = stop ? S_HALT : S_WAIT;

  always_comb begin
    wait_next = S_WAIT;
    if (stop)
      wait_next = S_HALT;
    else if (rise)
      wait_next = S_T0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      step_q <= 1'b0;
    else
      step_q <= step;
  end
`else
  assign fin       = stop ? S_HALT : S_T0;
  assign wait_next = S_T0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_RESET;
      cnt   <= 2'd0;
    end else begin
      cnt <= hold ? cnt + 2'd1 : 2'd0;
      unique case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    if (!hold) state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3: begin
          if (c_halt)
            state <= S_HALT;
          else
            state <= last ? fin : S_T4;
        end
        S_T4:    state <= last ? fin : S_T5;
        S_T5:    state <= last ? fin : S_T6;
        S_T6:    if (!hold) state <= last ? fin : S_T7;
        S_T7:    state <= fin;
        S_HALT:  state <= S_HALT;
        S_WAIT:  state <= wait_next;
        default: state <= S_RESET;
      endcase
    end
  end

  assign run = !(state inside {S_RESET, S_HALT, S_WAIT});

  always_comb begin
    ctrl      = '0;
    operation = '0;
    unique case (state)
      S_T0: ctrl = PCOUT | MARIN | INCPC;
      S_T1: ctrl = READ | MDRIN | stall;
      S_T2: ctrl = MDROUT | IRIN;
      S_T3: begin
        unique case (1'b1)
          c_alu, c_imm: ctrl = GRB | ROUT | YIN;
          c_neg: begin
            ctrl      = GRB | ROUT | ZLIN;
            operation = opc;
          end
          c_md:   ctrl = GRA | ROUT | YIN;
          c_mem:  ctrl = GRB | BAOUT | YIN;
          c_br:   ctrl = GRA | ROUT | CONIN;
          c_jr:   ctrl = GRA | ROUT | PCIN;
          c_in:   ctrl = INPOUT | GRA | RIN;
          c_out:  ctrl = GRA | ROUT | OUTPIN;
          c_mfhi: ctrl = HIOUT | GRA | RIN;
          c_mflo: ctrl = LOOUT | GRA | RIN;
          default: ctrl = '0;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          c_alu: begin
            ctrl      = GRC | ROUT | ZLIN;
            operation = opc;
          end
          c_imm: begin
            ctrl      = COUT | ZLIN;
            operation = imm_op;
          end
          c_neg: ctrl = ZLOUT | GRA | RIN;
          c_md:  ctrl = GRB | ROUT | ZLIN | ZHIN;
          c_mem: begin
            ctrl      = COUT | ZLIN;
            operation = 5'd3;
          end
          c_br:  ctrl = PCOUT | YIN;
          default: ctrl = '0;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          c_alu, c_imm, c_ldi: ctrl = ZLOUT | GRA | RIN;
          c_md:       ctrl = ZLOUT | LOIN;
          c_ld, c_st: ctrl = ZLOUT | MARIN;
          c_br: begin
            ctrl      = COUT | ZLIN;
            operation = 5'd3;
          end
          default: ctrl = '0;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          c_md: ctrl = ZHOUT | HIIN;
          c_ld: ctrl = READ | MDRIN | stall;
          c_st: ctrl = GRA | ROUT | MDRIN;
          c_br: ctrl = con ? (ZLOUT | PCIN) : '0;
          default: ctrl = '0;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          c_ld: ctrl = MDROUT | GRA | RIN;
          c_st: ctrl = RAMWE;
          default: ctrl = '0;
        endcase
      end
      default: ctrl = '0;
    endcase
  end

endmodule
